// File: rtl/uart_byte_transmitter_pkg.sv
// -----------------------------------------------------------------------------
// uart_byte_transmitter_pkg
// Shared definitions for the UART byte transmitter:
//   - tx_state_e  : transmit FSM state encoding (2 bits)
//   - UART_ADDR_* : CPU memory-mapped UART register addresses
//   - DATA_BITS / FRAME_BITS : 8N1 frame geometry
//   - symbol_time : clock cycles per serial bit for a given clock/baud pair
// -----------------------------------------------------------------------------
package uart_byte_transmitter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam logic [31:0] UART_ADDR_CTRL    = 32'h8000_0000;
    localparam logic [31:0] UART_ADDR_RX_DATA = 32'h8000_0004;
    localparam logic [31:0] UART_ADDR_TX_DATA = 32'h8000_0008;
    localparam logic [31:0] UART_ADDR_STATUS  = 32'h8000_000C;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    function automatic int symbol_time(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_byte_transmitter_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous first-word-fall-through FIFO buffering bytes for the transmitter.
// Ports:
//   clk_i    in   clock, rising edge
//   rst_ni   in   asynchronous reset, active low (empties the FIFO)
//   push_i   in   write din_i this edge (ignored when full)
//   din_i    in   WIDTH data to write
//   pop_i    in   remove head entry this edge (ignored when empty)
//   dout_o   out  head entry, valid whenever empty_o is low
//   full_o   out  count_o == DEPTH
//   empty_o  out  count_o == 0
//   count_o  out  number of stored entries, $clog2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the count alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/uart_byte_transmitter.sv
// -----------------------------------------------------------------------------
// uart_byte_transmitter
// Accepts bytes on a valid/ready handshake, buffers them in uart_tx_fifo and
// sends each one on SOut as an 8N1 frame (start, 8 data bits LSB first, stop).
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous reset, active low
//   DataIn       in   byte to transmit
//   DataInValid  in   DataIn is valid this cycle
//   DataInReady  out  a byte can be accepted this cycle (registered)
//   SOut         out  serial line, idles high (registered)
//   TxBusy       out  frame in flight or FIFO non-empty (registered)
// -----------------------------------------------------------------------------
module uart_byte_transmitter
    import uart_byte_transmitter_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] DataIn,
    input  logic       DataInValid,
    output logic       DataInReady,
    output logic       SOut,
    output logic       TxBusy
);
    localparam int SYMBOL_TIME = symbol_time(CLOCK_FREQ, BAUD_RATE);
    localparam int TIMER_W     = (SYMBOL_TIME > 1) ? $clog2(SYMBOL_TIME) : 1;
    localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1;

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SYMBOL_TIME - 1);
    localparam logic [2:0]         LAST_BIT   = 3'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0]   DEPTH_CNT  = CNT_W'(FIFO_DEPTH);

    tx_state_e          state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               sout_q, sout_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;

    logic               push, pop;
    logic [7:0]         fifo_dout;
    logic               fifo_full, fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W-1:0]   count_nxt;

    // Bytes offered while DataInReady is low are dropped, not held.
    assign push = DataInValid & ready_q & ~fifo_full;

    uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (push),
        .din_i   (DataIn),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        sout_d  = sout_q;
        pop     = 1'b0;

        unique case (state_q)
            IDLE: begin
                sout_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    sout_d  = 1'b0;
                    timer_d = '0;
                    state_d = START;
                end
            end
            START: begin
                if (timer_q == TIMER_LAST) begin
                    timer_d = '0;
                    idx_d   = '0;
                    sout_d  = shift_q[0];
                    state_d = DATA;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DATA: begin
                if (timer_q == TIMER_LAST) begin
                    timer_d = '0;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == LAST_BIT) begin
                        sout_d  = 1'b1;
                        state_d = STOP;
                    end else begin
                        // SOut is registered, so present the next bit before shifting.
                        shift_d = shift_q >> 1;
                        sout_d  = shift_q[1];
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            STOP: begin
                if (timer_q == TIMER_LAST) begin
                    timer_d = '0;
                    if (!fifo_empty) begin
                        // Chain straight into the next start bit with no idle gap.
                        pop     = 1'b1;
                        shift_d = fifo_dout;
                        sout_d  = 1'b0;
                        state_d = START;
                    end else begin
                        sout_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                sout_d  = 1'b1;
                state_d = IDLE;
            end
        endcase

        count_nxt = fifo_count + CNT_W'(push) - CNT_W'(pop);
        ready_d   = (count_nxt < DEPTH_CNT);
        busy_d    = (state_d != IDLE) || (count_nxt != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            sout_q  <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            sout_q  <= sout_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign DataInReady = ready_q;
    assign SOut        = sout_q;
    assign TxBusy      = busy_q;

endmodule

// File: tb/tb_uart_byte_transmitter.sv
`timescale 1ns/1ps
module tb_uart_byte_transmitter;

    localparam int CLOCK_FREQ = 1000;
    localparam int BAUD_RATE  = 100;
    localparam int FIFO_DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] DataIn = 8'h00;
    logic       DataInValid = 1'b0;
    logic       DataInReady;
    logic       SOut;
    logic       TxBusy;

    uart_byte_transmitter #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .DataIn      (DataIn),
        .DataInValid (DataInValid),
        .DataInReady (DataInReady),
        .SOut        (SOut),
        .TxBusy      (TxBusy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];   // bytes accepted by the DUT, in order
    logic [8:0] rx_q[$];    // {framing_ok, byte} decoded from SOut

    typedef struct {
        int   offs;
        logic sout;
        logic busy;
        logic ready;
    } vec_t;

    vec_t vecs[17];

    // Line decoder: samples each bit in the middle of its 10-cycle symbol.
    logic       mon_act  = 1'b0;
    int         mon_cnt  = 0;
    logic [7:0] mon_byte = 8'h00;
    logic       mon_ok   = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_act <= 1'b0;
        end else if (!mon_act) begin
            if (SOut == 1'b0) begin
                mon_act <= 1'b1;
                mon_cnt <= 1;
                mon_ok  <= 1'b1;
            end
        end else begin
            mon_cnt <= mon_cnt + 1;
            if (mon_cnt == 5 && SOut !== 1'b0) mon_ok <= 1'b0;
            if (mon_cnt >= 15 && mon_cnt <= 85 && (mon_cnt % 10) == 5)
                mon_byte[3'((mon_cnt - 15) / 10)] <= SOut;
            if (mon_cnt == 95) begin
                rx_q.push_back({mon_ok & (SOut === 1'b1), mon_byte});
                mon_act <= 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        DataIn      = b;
        DataInValid = 1'b1;
        if (DataInReady) exp_q.push_back(b);
        tick();
        DataInValid = 1'b0;
    endtask

    task automatic drain(input string name, input int n, input int budget);
        int waited = 0;
        logic [8:0] r;
        logic [7:0] e;
        while (rx_q.size() < n && waited < budget) begin
            tick();
            waited++;
        end
        check_val({name, "_frames"}, rx_q.size() >= n ? n : rx_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (rx_q.size() == 0) break;
            r = rx_q.pop_front();
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            check_val({name, "_byte"}, int'(r), int'({1'b1, e}));
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int waited = 0;
        while (TxBusy !== 1'b0 && waited < budget) begin
            tick();
            waited++;
        end
        check_bit({name, "_idle"}, TxBusy, 1'b0);
    endtask

    initial begin
        int   cyc;
        logic rdy;
        int   lows;
        logic exp_rdy [6];

        // offset after push edge k, SOut, TxBusy, DataInReady for byte 0xA5
        vecs[0]  = '{0,   1'b1, 1'b1, 1'b1};
        vecs[1]  = '{1,   1'b0, 1'b1, 1'b1};
        vecs[2]  = '{10,  1'b0, 1'b1, 1'b1};
        vecs[3]  = '{11,  1'b1, 1'b1, 1'b1};
        vecs[4]  = '{20,  1'b1, 1'b1, 1'b1};
        vecs[5]  = '{21,  1'b0, 1'b1, 1'b1};
        vecs[6]  = '{30,  1'b0, 1'b1, 1'b1};
        vecs[7]  = '{31,  1'b1, 1'b1, 1'b1};
        vecs[8]  = '{41,  1'b0, 1'b1, 1'b1};
        vecs[9]  = '{51,  1'b0, 1'b1, 1'b1};
        vecs[10] = '{61,  1'b1, 1'b1, 1'b1};
        vecs[11] = '{71,  1'b0, 1'b1, 1'b1};
        vecs[12] = '{81,  1'b1, 1'b1, 1'b1};
        vecs[13] = '{90,  1'b1, 1'b1, 1'b1};
        vecs[14] = '{91,  1'b1, 1'b1, 1'b1};
        vecs[15] = '{100, 1'b1, 1'b1, 1'b1};
        vecs[16] = '{101, 1'b1, 1'b0, 1'b1};

        exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset
        #2 rst_n = 1'b0;
        repeat (3) tick();
        check_bit("rst_sout", SOut, 1'b1);
        check_bit("rst_ready", DataInReady, 1'b0);
        check_bit("rst_busy", TxBusy, 1'b0);
        rst_n = 1'b1;
        check_bit("release_ready_before_edge", DataInReady, 1'b0);
        tick();
        check_bit("release_ready", DataInReady, 1'b1);
        check_bit("release_sout", SOut, 1'b1);
        check_bit("release_busy", TxBusy, 1'b0);
        repeat (2) tick();

        // Single byte 0xA5, table-driven timing
        send(8'hA5);
        cyc = 0;
        for (int i = 0; i < 17; i++) begin
            while (cyc < vecs[i].offs) begin
                tick();
                cyc++;
            end
            check_bit($sformatf("a5_sout_k+%0d", vecs[i].offs), SOut, vecs[i].sout);
            check_bit($sformatf("a5_busy_k+%0d", vecs[i].offs), TxBusy, vecs[i].busy);
            check_bit($sformatf("a5_ready_k+%0d", vecs[i].offs), DataInReady, vecs[i].ready);
        end
        drain("a5", 1, 50);
        wait_idle("a5", 20);

        // Back-to-back 0x00 then 0xFF
        send(8'h00);
        send(8'hFF);
        cyc = 1;
        check_bit("b2b_start1", SOut, 1'b0);
        while (cyc < 90) begin tick(); cyc++; end
        check_bit("b2b_bit7_of_00", SOut, 1'b0);
        tick(); cyc++;
        check_bit("b2b_stop_first", SOut, 1'b1);
        while (cyc < 100) begin tick(); cyc++; end
        check_bit("b2b_stop_last", SOut, 1'b1);
        tick(); cyc++;
        check_bit("b2b_start2_no_gap", SOut, 1'b0);
        check_bit("b2b_busy", TxBusy, 1'b1);
        while (cyc < 110) begin tick(); cyc++; end
        check_bit("b2b_start2_end", SOut, 1'b0);
        tick(); cyc++;
        check_bit("b2b_ff_bit0", SOut, 1'b1);
        drain("b2b", 2, 250);
        wait_idle("b2b", 50);

        // Overflow: bytes 1..6 on consecutive edges
        for (int i = 0; i < 6; i++) begin
            rdy = DataInReady;
            check_bit($sformatf("ovf_ready_edge_k+%0d", i), rdy, exp_rdy[i]);
            DataIn      = 8'(i + 1);
            DataInValid = 1'b1;
            if (rdy) exp_q.push_back(8'(i + 1));
            tick();
        end
        DataInValid = 1'b0;
        cyc = 5;
        check_bit("ovf_busy", TxBusy, 1'b1);

        // Full-release: pop at end of frame 1 reopens the FIFO
        while (cyc < 100) begin tick(); cyc++; end
        check_bit("full_ready_before_pop", DataInReady, 1'b0);
        tick(); cyc++;
        check_bit("full_ready_after_pop", DataInReady, 1'b1);
        check_bit("full_next_start", SOut, 1'b0);
        send(8'h07);
        check_bit("full_refilled", DataInReady, 1'b0);
        drain("ovf", 6, 700);
        check_val("ovf_exp_empty", exp_q.size(), 0);
        wait_idle("ovf", 200);

        // Reset mid-frame during data bit 3 (0xC3 bit3 = 0), with two bytes queued
        send(8'hC3);
        send(8'h3C);
        send(8'h99);
        cyc = 2;
        while (cyc < 45) begin tick(); cyc++; end
        check_bit("mid_bit3_low", SOut, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_bit("mid_async_sout", SOut, 1'b1);
        check_bit("mid_async_ready", DataInReady, 1'b0);
        check_bit("mid_async_busy", TxBusy, 1'b0);
        repeat (3) tick();
        exp_q.delete();
        rst_n = 1'b1;
        tick();
        check_bit("mid_release_ready", DataInReady, 1'b1);
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            if (SOut !== 1'b1) lows++;
            tick();
        end
        check_val("mid_sout_low_cycles", lows, 0);
        check_bit("mid_fifo_flushed", TxBusy, 1'b0);
        check_val("mid_no_frames", rx_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
